// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The source side drives operands and accepts results (master);
// the adder consumes operands and presents results (slave).
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             zr;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, carry, zr
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, carry, zr
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, registered
// carry between bits. A result appears WIDTH clocks after acceptance and
// is held until the consumer takes it.
module serial_adder #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           reset,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic             c_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             zr_r;
    logic             accept_s;
    logic             last_s;
    logic [1:0]       fa_s;
    logic [WIDTH-1:0] sum_nx_s;

    // One full-adder cell built from two half adders; returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic hs1;
        logic hc1;
        logic hs2;
        logic hc2;
        hs1 = x ^ y;
        hc1 = x & y;
        hs2 = hs1 ^ ci;
        hc2 = hs1 & ci;
        return {hc1 | hc2, hs2};
    endfunction

    assign accept_s = (state_r == IDLE) && bus.in_valid;
    assign last_s   = (cnt_r == CW'(WIDTH - 1));
    assign fa_s     = full_add(a_sh_r[0], b_sh_r[0], c_r);
    assign sum_nx_s = {fa_s[0], sum_sh_r[WIDTH-1:1]};

    // Handshake flags come straight from the state register, never from inputs.
    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.sum       = sum_r;
    assign bus.carry     = carry_r;
    assign bus.zr        = zr_r;

    // State register; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Operand shifters, carry link, bit counter and the held result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            sum_sh_r <= {WIDTH{1'b0}};
            c_r      <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            zr_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_sh_r   <= bus.a;
                        b_sh_r   <= bus.b;
                        c_r      <= bus.cin;
                        cnt_r    <= {CW{1'b0}};
                        sum_sh_r <= {WIDTH{1'b0}};
                    end
                end
                RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    sum_sh_r <= sum_nx_s;
                    c_r      <= fa_s[1];
                    cnt_r    <= cnt_r + CW'(1'b1);
                    // Final bit: publish the complete word, its carry and zero flag.
                    if (last_s) begin
                        sum_r   <= sum_nx_s;
                        carry_r <= fa_s[1];
                        zr_r    <= (sum_nx_s == {WIDTH{1'b0}});
                    end
                end
                DONE: begin
                    // Result held until the consumer takes it.
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, multi-cycle
// corner sequences, and a randomized run against an arithmetic model.
module tb_serial_adder;
    localparam int W = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        carry;
        logic        zr;
    } vec_t;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one operation from IDLE and wait for its result (out_ready held 0).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          output int lat, output int rdy_bad);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        step();
        lat     = 0;
        rdy_bad = 0;
        while (!bus.out_valid && lat < 64) begin
            if (bus.in_ready) rdy_bad++;
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.cin      = 1'($urandom);
            bus.in_valid = 1'($urandom);
            step();
            lat++;
        end
        bus.in_valid = 1'b0;
    endtask

    vec_t        vecs[6];
    int          lat;
    int          rdy_bad;
    int          acc_cyc[$];
    int          nres;
    logic [16:0] exp_q[$];
    logic [16:0] e;
    logic [15:0] pa;
    logic [15:0] pb;
    logic        pc;
    int          sent;
    int          got;
    int          cyc;

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 16'h0000;
        bus.b         = 16'h0000;
        bus.cin       = 1'b0;
        reset         = 1'b1;
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_carry", 32'(bus.carry), 32'd0);
        check("rst_zr", 32'(bus.zr), 32'd0);
        bus.in_valid = 1'b1;
        step();
        check("rst_no_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        step();

        // Idle with in_valid low: nothing moves.
        repeat (3) step();
        check("idle_hold_ready", 32'(bus.in_ready), 32'd1);
        check("idle_hold_valid", 32'(bus.out_valid), 32'd0);

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            check("tbl_idle_ready", 32'(bus.in_ready), 32'd1);
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, rdy_bad);
            check("tbl_latency", 32'(lat), 32'd16);
            check("tbl_ready_low", 32'(rdy_bad), 32'd0);
            check("tbl_sum", 32'(bus.sum), 32'(vecs[i].sum));
            check("tbl_carry", 32'(bus.carry), 32'(vecs[i].carry));
            check("tbl_zr", 32'(bus.zr), 32'(vecs[i].zr));
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            check("tbl_back_idle", 32'(bus.in_ready), 32'd1);
        end

        // Backpressure: hold in DONE, ignore new operands, no accept on exit edge.
        run_op(16'h1234, 16'h1111, 1'b0, lat, rdy_bad);
        check("bp_latency", 32'(lat), 32'd16);
        for (int k = 0; k < 5; k++) begin
            bus.a        = 16'hAAAA;
            bus.b        = 16'h5555;
            bus.in_valid = 1'(k % 2);
            step();
            check("bp_sum", 32'(bus.sum), 32'h2345);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("bp_exit_ready", 32'(bus.in_ready), 32'd1);
        check("bp_exit_valid", 32'(bus.out_valid), 32'd0);
        check("bp_exit_sum", 32'(bus.sum), 32'h2345);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();

        // Reset between edges after 7 RUN edges.
        bus.a        = 16'hF0F0;
        bus.b        = 16'h0F0F;
        bus.cin      = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (7) step();
        #2;
        reset = 1'b1;
        #1;
        check("rrun_valid", 32'(bus.out_valid), 32'd0);
        check("rrun_ready", 32'(bus.in_ready), 32'd1);
        check("rrun_sum", 32'(bus.sum), 32'd0);
        #3;
        reset = 1'b0;
        step();
        run_op(16'h00FF, 16'h0001, 1'b0, lat, rdy_bad);
        check("rrun_after_lat", 32'(lat), 32'd16);
        check("rrun_after_sum", 32'(bus.sum), 32'h0100);
        check("rrun_after_carry", 32'(bus.carry), 32'd0);

        // Reset while a result is waiting in DONE.
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, rdy_bad);
        check("rdone_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rdone_valid", 32'(bus.out_valid), 32'd0);
        check("rdone_carry", 32'(bus.carry), 32'd0);
        check("rdone_zr", 32'(bus.zr), 32'd0);
        #3;
        reset = 1'b0;
        step();

        // Streaming with both sides always ready.
        bus.a         = 16'h8000;
        bus.b         = 16'h8000;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        nres          = 0;
        for (int k = 0; k < 130; k++) begin
            bus.in_valid = (acc_cyc.size() < 5);
            if (acc_cyc.size() == 5 && nres == 5 && bus.in_ready) break;
            if (bus.in_valid && bus.in_ready) acc_cyc.push_back(k);
            if (bus.out_valid) begin
                check("stream_sum", 32'(bus.sum), 32'h0000);
                check("stream_carry", 32'(bus.carry), 32'd1);
                check("stream_zr", 32'(bus.zr), 32'd1);
                nres++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        check("stream_accepts", 32'(acc_cyc.size()), 32'd5);
        check("stream_results", 32'(nres), 32'd5);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check("stream_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd18);
        end

        // Randomized operations with random gaps on both sides.
        bus.out_ready = 1'b0;
        step();
        sent = 0;
        got  = 0;
        cyc  = 0;
        pa   = 16'($urandom);
        pb   = 16'($urandom);
        pc   = 1'($urandom);
        while (got < 200 && cyc < 20000) begin
            bus.a         = pa;
            bus.b         = pb;
            bus.cin       = pc;
            bus.in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({1'b0, pa} + {1'b0, pb} + 17'(pc));
                sent++;
                pa = 16'($urandom);
                pb = 16'($urandom);
                pc = 1'($urandom);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("rand_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rand_sum", 32'({bus.carry, bus.sum}), 32'(e));
                    check("rand_zr", 32'(bus.zr), 32'(e[15:0] == 16'h0000));
                end
                got++;
            end
            step();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("rand_count", 32'(got), 32'd200);
        check("rand_leftover", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
